// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous pulse train over a fixed
// gate window of GATE_CYCLES clk cycles and publishes the count at the end of
// each window. Windows run back to back while enable is held high.
module freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int COUNT_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sig_in,
    input  logic               enable,
    output logic [COUNT_W-1:0] result,
    output logic               result_valid,
    output logic               overflow,
    output logic               busy
);

    localparam int GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                 prev_q, prev_d;
    logic [GATE_W-1:0]    gate_cnt_q, gate_cnt_d;
    logic [COUNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic                 sat_q, sat_d;
    logic [COUNT_W-1:0]   result_q, result_d;
    logic                 result_valid_q, result_valid_d;
    logic                 overflow_q, overflow_d;

    logic                 sig_sync;
    logic                 sig_rise;
    logic [COUNT_W-1:0]   cnt_inc;
    logic                 sat_inc;

    assign sig_sync = sync_q[SYNC_STAGES-1];
    assign sig_rise = sig_sync & ~prev_q;

    // Synchronizer shift and previous-sample register; these run regardless of enable
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        prev_d = sig_sync;
    end

    // Gate sequencing, saturating edge count and result publication
    always_comb begin
        state_d        = state_q;
        gate_cnt_d     = gate_cnt_q;
        edge_cnt_d     = edge_cnt_q;
        sat_d          = sat_q;
        result_d       = result_q;
        overflow_d     = overflow_q;
        result_valid_d = 1'b0;
        cnt_inc        = edge_cnt_q;
        sat_inc        = sat_q;

        if (sig_rise) begin
            if (edge_cnt_q == CNT_MAX) begin
                sat_inc = 1'b1;
            end else begin
                cnt_inc = edge_cnt_q + 1'b1;
            end
        end

        if (!enable) begin
            state_d    = IDLE;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            sat_d      = 1'b0;
        end else begin
            // In IDLE gate_cnt is 0, so the cycle enable is first seen is window cycle 0
            state_d = GATE;
            if (gate_cnt_q == GATE_LAST) begin
                result_d       = cnt_inc;
                overflow_d     = sat_inc;
                result_valid_d = 1'b1;
                gate_cnt_d     = '0;
                edge_cnt_d     = '0;
                sat_d          = 1'b0;
            end else begin
                gate_cnt_d = gate_cnt_q + 1'b1;
                edge_cnt_d = cnt_inc;
                sat_d      = sat_inc;
            end
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            sync_q         <= '0;
            prev_q         <= 1'b0;
            gate_cnt_q     <= '0;
            edge_cnt_q     <= '0;
            sat_q          <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            prev_q         <= prev_d;
            gate_cnt_q     <= gate_cnt_d;
            edge_cnt_q     <= edge_cnt_d;
            sat_q          <= sat_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            overflow_q     <= overflow_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q == GATE);

endmodule
